sync_handshake_pulse: RTL and testbench
=======================================

// Module: sync_handshake_pulse
// PURPOSE
// - Toggle-based request/acknowledge synchroniser. It carries a single enable event from source clock sCLK
//   to one pulse on destination clock dCLK, and returns an acknowledge to the source.
// - It is the control core under register and bus crossing blocks. The parent captures data on sEN and
//   loads it on dPulse. Setup and hold are met because at least 2 dCLK edges occur between the
//   source capture and dPulse.
// PARAMETERS
// - init         1'b0  Reset value of the toggle and of every destination flop.
// - delayreturn  1'b0  1: ack returns from dLastState, so dPulse has fired before sRDY can rise.
//                      0: ack returns from dSyncReg2, which is one dCLK faster.
// PORTS
// - Clocking and reset: one clock per side of the crossing (sCLK source, dCLK destination).
//   The reset is asynchronous and active-low: sRST, shared by both sides.
// - sCLK    in   1  Source clock.
// - sRST    in   1  Asynchronous active-low reset. Clears both domains.
// - dCLK    in   1  Destination clock. Asynchronous to sCLK.
// - sEN     in   1  Source request. Legal only while sRDY=1.
// - sRDY    out  1  Source may issue sEN.
// - dPulse  out  1  One-dCLK pulse per accepted sEN.
// BEHAVIOUR
// - Source state, all reset asynchronously:
//   - sToggleReg resets to init.
//   - sSyncReg1 and sSyncReg2 reset to !init.
//   - sRDYReg resets to 0.
// - Destination state: dSyncReg1, dSyncReg2 and dLastState all reset to init.
// - On each sCLK edge:
//   - sSyncReg1 <= ackSrc, then sSyncReg2 <= sSyncReg1.
//   - If sEN: sToggleReg flips and sRDYReg <= 0.
//   - Otherwise, if sSyncReg2 == sToggleReg: sRDYReg <= 1.
// - On each dCLK edge: dSyncReg1 <= sToggleReg, dSyncReg2 <= dSyncReg1, dLastState <= dSyncReg2.
// - Outputs:
//   - dPulse = dSyncReg2 ^ dLastState (combinational).
//   - ackSrc = delayreturn ? dLastState : dSyncReg2.
//   - sRDY = sRDYReg.
// - After reset:
//   - sRDY stays 0. The !init in the source sync flops resolves within 2 sCLK, then sRDY rises on the 3rd sCLK.
//   - dPulse stays 0.
// - Latency:
//   - dPulse is asserted 2-3 dCLK after the sCLK edge that accepted sEN.
//   - sRDY falls on the accepting edge and returns after about 3 dCLK + 3 sCLK (delayreturn=1).
// - Handshake:
//   - Exactly one dPulse per accepted sEN. dPulse is high for exactly one dCLK.
//   - sEN while sRDY=0 is a protocol violation. Behaviour is undefined; a simulation-only assertion flags it.
// - Reset mid-transfer: all flops return to their reset values. No dPulse is issued for the pending
//   request, and sRDY is 0 until the reset sequence above completes.
// - Flops that capture the other domain carry the (* ASYNC_REG = "TRUE" *) attribute:
//   dSyncReg1/2 and sSyncReg1/2.
// - Simulation initial values for all state are 0/1 alternation. They are disabled by BSV_NO_INITIAL_BLOCKS.
// - Macros used:
//   - BSV_ASSIGNMENT_DELAY on every nonblocking assignment.
//   - BSV_POSITIVE_RESET may flip the reset polarity project-wide; the default is active-low as above.
// STRUCTURE
// - Shared bsv_defs include holds BSV_ASSIGNMENT_DELAY, BSV_RESET_VALUE and BSV_RESET_EDGE.
// - Sub-module sync_bit2: 2-flop single-bit synchroniser with a parameterised reset value.
//   - Instantiated once per direction.
//   - The destination third flop (dLastState) and the source toggle logic stay in the top module.
// - Parent usage:
//   - Data register loads on sEN in the sCLK domain.
//   - Destination register loads on dPulse.
// TESTING
// - All benches use sCLK period 20 and dCLK period 11 (also rerun with the clocks swapped); width 8 data wrapper.
// - Reset: hold sRST=0 for 5 sCLK, then release.
//   - sRDY=0 and dPulse=0 during reset.
//   - sRDY=1 within 3 sCLK of release, with no dPulse.
// - Single transfer: assert sEN for one sCLK while sRDY=1.
//   - sRDY falls on the next sCLK edge.
//   - Exactly one dPulse occurs 2-3 dCLK later.
//   - sRDY returns after dPulse (delayreturn=1).
// - Streaming: tie sEN=sRDY and count 1000 accepted sEN.
//   - dPulse count equals 1000.
//   - A wrapper data register captures the counter values 0,1,2,... with no skip or duplicate.
// - Mid-transfer reset: assert sRST one dCLK after sEN.
//   - No dPulse for that request.
//   - Normal operation after release.
// - delayreturn=0: repeat the single transfer.
//   - sRDY recovers one dCLK earlier.
//   - dPulse still occurs exactly once.

Source files
------------

// File: rtl/sync_handshake_pulse_pkg.sv
// ============================================================================
// Package : sync_handshake_pulse_pkg
// Purpose : Shared types and helpers for the toggle-based request/acknowledge
//           pulse synchroniser.
// Contents: ack_sel_e  - selects which destination flop returns the ack
//           sel_ack()  - picks the ack source bit from the selector
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
`default_nettype none

package sync_handshake_pulse_pkg;

  // Which destination flop is fed back to the source as the acknowledge.
  // ACK_FROM_LAST waits for the pulse to have fired before the source may
  // issue again; ACK_FROM_SYNC2 returns one destination clock earlier.
  typedef enum logic [0:0] {
    ACK_FROM_SYNC2 = 1'b0,
    ACK_FROM_LAST  = 1'b1
  } ack_sel_e;

  function automatic logic sel_ack(input ack_sel_e sel,
                                   input logic     last_state,
                                   input logic     sync2);
    return (sel == ACK_FROM_LAST) ? last_state : sync2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_handshake_pulse_sync_bit2.sv
// ============================================================================
// Module  : sync_handshake_pulse_sync_bit2
// Purpose : Two-flop single-bit synchroniser with a parameterised reset value.
//           Used once in each direction of the handshake crossing.
// Ports   : i_clk   - capturing (destination) clock
//           i_rst_n - asynchronous active-low reset
//           i_d     - bit from the other clock domain
//           o_q     - synchronised bit (two flops deep)
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
`default_nettype none

module sync_handshake_pulse_sync_bit2
  import sync_handshake_pulse_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  // Both stages sample a foreign-domain signal and must be placed together.
  (* ASYNC_REG = "TRUE" *) logic r_meta;
  (* ASYNC_REG = "TRUE" *) logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/sync_handshake_pulse.sv
// ============================================================================
// Module  : sync_handshake_pulse
// Purpose : Toggle-based request/acknowledge synchroniser. Each accepted
//           source enable flips a toggle that is carried into the destination
//           domain and turned into a single one-clock pulse there; the
//           synchronised toggle is returned to the source as the acknowledge.
// Params  : INIT         - reset value of the toggle and destination flops
//           DELAY_RETURN - 1: ack from the last-state flop (pulse has fired
//                          before ready rises); 0: ack from sync stage 2
// Ports   : i_s_clk   - source clock
//           i_s_rst_n - asynchronous active-low reset, clears both domains
//           i_d_clk   - destination clock (asynchronous to i_s_clk)
//           i_s_en    - source request, legal only while o_s_rdy = 1
//           o_s_rdy   - source may issue a request
//           o_d_pulse - one destination-clock pulse per accepted request
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
`default_nettype none

module sync_handshake_pulse
  import sync_handshake_pulse_pkg::*;
#(
  parameter logic INIT         = 1'b0,
  parameter logic DELAY_RETURN = 1'b0
) (
  input  logic i_s_clk,
  input  logic i_s_rst_n,
  input  logic i_d_clk,
  input  logic i_s_en,
  output logic o_s_rdy,
  output logic o_d_pulse
);

  localparam ack_sel_e c_ack_sel = ack_sel_e'(DELAY_RETURN);

  logic r_s_toggle;
  logic r_s_rdy;
  logic r_d_last;
  logic w_s_sync2;
  logic w_d_sync2;
  logic w_ack_src;

  // --------------------------------------------------------------------------
  // Source -> destination: carry the request toggle.
  // --------------------------------------------------------------------------
  sync_handshake_pulse_sync_bit2 #(
    .RESET_VAL (INIT)
  ) u_sync_s2d (
    .i_clk   (i_d_clk),
    .i_rst_n (i_s_rst_n),
    .i_d     (r_s_toggle),
    .o_q     (w_d_sync2)
  );

  // --------------------------------------------------------------------------
  // Destination -> source: return the acknowledge. Resetting to the inverse
  // of the toggle keeps ready low until the feedback path has been flushed
  // with the real destination state after reset.
  // --------------------------------------------------------------------------
  sync_handshake_pulse_sync_bit2 #(
    .RESET_VAL (~INIT)
  ) u_sync_d2s (
    .i_clk   (i_s_clk),
    .i_rst_n (i_s_rst_n),
    .i_d     (w_ack_src),
    .o_q     (w_s_sync2)
  );

  // --------------------------------------------------------------------------
  // Source toggle and ready. Ready returns only once the acknowledged toggle
  // matches the local one, i.e. the previous request has crossed over.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_s_clk or negedge i_s_rst_n) begin
    if (!i_s_rst_n) begin
      r_s_toggle <= INIT;
      r_s_rdy    <= 1'b0;
    end else if (i_s_en) begin
      r_s_toggle <= ~r_s_toggle;
      r_s_rdy    <= 1'b0;
    end else if (w_s_sync2 == r_s_toggle) begin
      r_s_rdy    <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Destination edge detector on the synchronised toggle.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_d_clk or negedge i_s_rst_n) begin
    if (!i_s_rst_n) begin
      r_d_last <= INIT;
    end else begin
      r_d_last <= w_d_sync2;
    end
  end

  assign w_ack_src = sel_ack(c_ack_sel, r_d_last, w_d_sync2);
  assign o_d_pulse = w_d_sync2 ^ r_d_last;
  assign o_s_rdy   = r_s_rdy;

`ifndef SYNTHESIS
  // A request while not ready would flip the toggle twice before the
  // destination sees it, silently losing a pulse.
  a_en_only_when_rdy : assert property (
    @(posedge i_s_clk) disable iff (!i_s_rst_n) i_s_en |-> r_s_rdy
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_handshake_pulse.sv
// ============================================================================
// Module  : tb_sync_handshake_pulse
// Purpose : Self-checking bench for sync_handshake_pulse. Two instances run
//           side by side (ack from last-state and ack from sync stage 2).
//           Expected edge times are computed from the fixed clock phases:
//           source posedges at 10+20m ns, destination posedges at 5.5+11k ns.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
`default_nettype none

module tb_sync_handshake_pulse;

  logic       sclk  = 1'b0;
  logic       dclk  = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] en;
  logic [1:0] rdy;
  logic [1:0] pulse;

  // index 0: ack returned from last-state flop, index 1: from sync stage 2
  sync_handshake_pulse #(.INIT(1'b0), .DELAY_RETURN(1'b1)) u_dut_dr1 (
    .i_s_clk   (sclk),
    .i_s_rst_n (rst_n),
    .i_d_clk   (dclk),
    .i_s_en    (en[0]),
    .o_s_rdy   (rdy[0]),
    .o_d_pulse (pulse[0])
  );

  sync_handshake_pulse #(.INIT(1'b0), .DELAY_RETURN(1'b0)) u_dut_dr0 (
    .i_s_clk   (sclk),
    .i_s_rst_n (rst_n),
    .i_d_clk   (dclk),
    .i_s_en    (en[1]),
    .o_s_rdy   (rdy[1]),
    .o_d_pulse (pulse[1])
  );

  always #10  sclk = ~sclk;
  always #5.5 dclk = ~dclk;

  int n_total = 0;
  int n_bad   = 0;

  int   acc       [2];   // requests the model expects a pulse for
  int   pulse_cnt [2];
  int   dbl       [2];   // pulse seen high on two consecutive samples
  bit   prev_p    [2];
  int   t_pulse   [2];   // half-ns time of last pulse rising edge
  int   t_rdy     [2];   // half-ns time of last ready rising edge
  logic [7:0] src_cnt  [2];
  logic [7:0] src_data [2];
  logic [7:0] dst_data [2];
  logic [7:0] exp_dst  [2];
  int   seq_err   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int now_h();
    return int'($realtime * 2.0);
  endfunction

  // next destination / source rising edge strictly after h (half-ns units)
  function automatic int nd(input int h);
    if (h < 11) return 11;
    return 11 + 22 * ((h - 11) / 22 + 1);
  endfunction

  function automatic int ns(input int h);
    if (h < 20) return 20;
    return 20 + 40 * ((h - 20) / 40 + 1);
  endfunction

  function automatic int ns3(input int h);
    return ns(ns(ns(h)));
  endfunction

  // ---------------------------------------------------------------- monitors
  always @(negedge dclk) begin
    for (int i = 0; i < 2; i++) begin
      if (pulse[i] === 1'b1) pulse_cnt[i] <= pulse_cnt[i] + 1;
      if (pulse[i] === 1'b1 && prev_p[i]) dbl[i] <= dbl[i] + 1;
      prev_p[i] <= (pulse[i] === 1'b1);
    end
  end

  always @(posedge pulse[0]) t_pulse[0] <= now_h();
  always @(posedge pulse[1]) t_pulse[1] <= now_h();
  always @(posedge rdy[0])   t_rdy[0]   <= now_h();
  always @(posedge rdy[1])   t_rdy[1]   <= now_h();

  // 8-bit data wrapper: source register loads a running count on accept,
  // destination register loads it on the pulse.
  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        src_cnt[i]  <= 8'd0;
        src_data[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (en[i] && rdy[i]) begin
          src_data[i] <= src_cnt[i];
          src_cnt[i]  <= src_cnt[i] + 8'd1;
        end
      end
    end
  end

  always @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        exp_dst[i]  <= 8'd0;
        dst_data[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pulse[i] === 1'b1) begin
          dst_data[i] <= src_data[i];
          if (src_data[i] !== exp_dst[i]) seq_err[i] <= seq_err[i] + 1;
          exp_dst[i] <= exp_dst[i] + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- tasks
  task automatic wait_rdy(input string tag);
    for (int k = 0; k < 40 && rdy !== 2'b11; k++) @(negedge sclk);
    chk({tag, "_rdy_up"}, {30'd0, rdy}, 32'd3);
  endtask

  task automatic release_and_check(input string tag);
    int h_rel;
    h_rel = now_h();
    rst_n = 1'b1;
    wait_rdy(tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_rdy_time"}, t_rdy[i], ns3(h_rel));
      chk({tag, "_no_pulse"}, pulse_cnt[i], acc[i]);
    end
  endtask

  task automatic single_xfer(input string tag);
    int h_acc;
    @(negedge sclk);
    en    = 2'b11;
    h_acc = now_h() + 20;
    @(posedge sclk);
    #1;
    chk({tag, "_rdy_fall"}, {30'd0, rdy}, 32'd0);
    @(negedge sclk);
    en = 2'b00;
    acc[0]++;
    acc[1]++;
    wait_rdy(tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_pulse_time"}, t_pulse[i], nd(nd(h_acc)));
      chk({tag, "_pulse_cnt"}, pulse_cnt[i], acc[i]);
    end
    // slow return waits for the last-state flop, fast return for sync stage 2
    chk({tag, "_rdy_slow"}, t_rdy[0], ns3(nd(nd(nd(h_acc)))));
    chk({tag, "_rdy_fast"}, t_rdy[1], ns3(nd(nd(h_acc))));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int         s_cnt [2];
    int         budget;
    logic [7:0] last;

    en = 2'b00;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge sclk);
    chk("reset_rdy", {30'd0, rdy}, 32'd0);
    chk("reset_pulse", {30'd0, pulse}, 32'd0);
    repeat (3) @(negedge sclk);
    release_and_check("reset");

    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 5)) @(negedge sclk);
      single_xfer("single");
    end

    // reset one destination clock after the request is accepted
    @(negedge sclk);
    en = 2'b11;
    @(posedge sclk);
    @(posedge dclk);
    #1;
    rst_n = 1'b0;
    en    = 2'b00;
    repeat (5) @(negedge sclk);
    chk("midrst_rdy", {30'd0, rdy}, 32'd0);
    release_and_check("midrst");
    repeat (4) @(negedge sclk);
    chk("midrst_late0", pulse_cnt[0], acc[0]);
    chk("midrst_late1", pulse_cnt[1], acc[1]);
    single_xfer("after_rst");

    // random-gated streaming, 1000 accepted requests per instance
    s_cnt[0] = 0;
    s_cnt[1] = 0;
    budget   = 0;
    while ((s_cnt[0] < 1000 || s_cnt[1] < 1000) && budget < 30000) begin
      @(negedge sclk);
      budget++;
      for (int i = 0; i < 2; i++) begin
        en[i] = (rdy[i] === 1'b1) && (s_cnt[i] < 1000) && ($urandom_range(0, 3) != 0);
        if (en[i]) begin
          s_cnt[i]++;
          acc[i]++;
        end
      end
    end
    @(negedge sclk);
    en = 2'b00;
    chk("stream_issued", s_cnt[0] + s_cnt[1], 2000);
    wait_rdy("stream");
    repeat (5) @(negedge sclk);
    for (int i = 0; i < 2; i++) begin
      chk("stream_pulses", pulse_cnt[i], acc[i]);
      chk("stream_width", dbl[i], 0);
      chk("stream_seq", seq_err[i], 0);
      last = exp_dst[i] - 8'd1;
      chk("stream_last", {24'd0, dst_data[i]}, {24'd0, last});
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
